alloc_bitmap32: RTL



---
 rtl/alloc_bitmap32.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alloc_bitmap32.sv
// 32-entry tag allocator: lowest-free priority encode, free-by-index, flush to RESET_MASK.
// Optional sticky double-free flag enabled by `define ALLOC_BITMAP32_DBL_FREE_ERR_EN.

module and32 (
    input  logic [31:0] a,
    output logic        y
);
    assign y = &a;
endmodule

module alloc_bitmap32 #(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter logic [31:0] RESET_MASK  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_req,
    output logic        alloc_ready,
    output logic [4:0]  alloc_idx,
    input  logic        free_valid,
    input  logic [4:0]  free_idx,
    input  logic        flush,
    output logic [31:0] busy_vec,
    output logic        full,
    output logic        empty,
    output logic [5:0]  count
`ifdef ALLOC_BITMAP32_DBL_FREE_ERR_EN
    ,
    output logic        err_dbl_free
`endif
);

    if (NUM_ENTRIES != 32) begin : g_bad_cfg
        $error("alloc_bitmap32: NUM_ENTRIES must be 32");
    end

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    localparam logic [5:0] RESET_COUNT = popcount32(RESET_MASK);

    logic [31:0] busy_q, busy_d;
    logic [5:0]  count_q, count_d;
    logic [4:0]  enc_idx;
    logic        enc_found;
    logic        alloc_fire;
    logic        free_fire;

    always_comb begin
        enc_idx   = '0;
        enc_found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!enc_found && !busy_q[i]) begin
                enc_idx   = i[4:0];
                enc_found = 1'b1;
            end
        end
    end

    and32 u_and32 (
        .a (busy_q),
        .y (full)
    );

    assign alloc_ready = ~full;
    assign alloc_idx   = enc_idx;
    assign busy_vec    = busy_q;
    assign count       = count_q;
    assign empty       = (busy_q == '0);

    // Index comes from pre-edge state, so a same-cycle freed slot is never re-issued.
    assign alloc_fire = alloc_req & alloc_ready;
    assign free_fire  = free_valid & busy_q[free_idx];

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (flush) begin
            busy_d  = RESET_MASK;
            count_d = RESET_COUNT;
        end else begin
            if (alloc_fire) busy_d[enc_idx]  = 1'b1;
            if (free_fire)  busy_d[free_idx] = 1'b0;
            case ({alloc_fire, free_fire})
                2'b10:   count_d = count_q + 6'd1;
                2'b01:   count_d = count_q - 6'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= RESET_MASK;
            count_q <= RESET_COUNT;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

`ifdef ALLOC_BITMAP32_DBL_FREE_ERR_EN
    logic err_q, err_d;

    // Sticky; only rst clears it, flush leaves it standing.
    always_comb begin
        err_d = err_q | (free_valid & ~busy_q[free_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_dbl_free = err_q;
`endif

endmodule
